// File: rtl/param_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | param_fifo_if : handshake/status bundle for param_fifo       |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
interface param_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic                  WRITE;
   logic [DATA_WIDTH-1:0] DATA_IN;
   logic                  READ;
   logic [DATA_WIDTH-1:0] DATA_OUT;
   logic                  VALID_OUT;
   logic                  FULL;
   logic                  EMPTY;
   logic                  almost_Full;
   logic                  almost_Empty;
   logic [AW:0]           FILL_LEVEL;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output WRITE, DATA_IN, READ,
      input  DATA_OUT, VALID_OUT, FULL, EMPTY, almost_Full, almost_Empty,
             FILL_LEVEL, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  WRITE, DATA_IN, READ,
      output DATA_OUT, VALID_OUT, FULL, EMPTY, almost_Full, almost_Empty,
             FILL_LEVEL, OVERFLOW, UNDERFLOW
   );
endinterface
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// +--------------------------------------------------------------+
// | param_fifo : parametrised synchronous circular-buffer FIFO   |
// | with registered output and almost-full/almost-empty flags.   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module param_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 1
) (
   input wire logic    CLK,
   input wire logic    RESET,
   param_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_valid_out;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [AW:0]           w_next_count;
   logic [31:0]           w_next_ext;

   // Status flags are registered copies of the count, so EMPTY/FULL
   // are exact and can gate acceptance directly.
   assign w_rd_acc = RESET & bus.READ & ~r_empty;
   assign w_wr_acc = RESET & bus.WRITE & (~r_full | w_rd_acc);

   always_comb begin
      w_next_count = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_next_count = r_count + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_next_count = r_count - 1'b1;
      end
   end

   assign w_next_ext = {{(31 - AW){1'b0}}, w_next_count};

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_data_out     <= '0;
         r_valid_out    <= 1'b0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_valid_out    <= w_rd_acc;
         r_count        <= w_next_count;
         r_full         <= (w_next_ext == DEPTH);
         r_empty        <= (w_next_ext == 32'd0);
         r_almost_full  <= (w_next_ext >= AF_THRESH);
         r_almost_empty <= (w_next_ext <= AE_THRESH);
         r_overflow     <= bus.WRITE & ~w_wr_acc;
         r_underflow    <= bus.READ & ~w_rd_acc;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= bus.DATA_IN;
      end
   end

   assign bus.DATA_OUT     = r_data_out;
   assign bus.VALID_OUT    = r_valid_out;
   assign bus.FULL         = r_full;
   assign bus.EMPTY        = r_empty;
   assign bus.almost_Full  = r_almost_full;
   assign bus.almost_Empty = r_almost_empty;
   assign bus.FILL_LEVEL   = r_count;
   assign bus.OVERFLOW     = r_overflow;
   assign bus.UNDERFLOW    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_param_fifo : directed + random bench for param_fifo       |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_param_fifo;
   localparam int unsigned DW  = 8;
   localparam int unsigned DEP = 8;
   localparam int unsigned AFT = DEP - 2;
   localparam int unsigned AET = 1;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   param_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

   param_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEP),
      .AF_THRESH (AFT),
      .AE_THRESH (AET)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout  = '0;
   logic          m_valid = 1'b0;
   logic          m_ovf   = 1'b0;
   logic          m_unf   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r);
      bit ra, wa;
      ra = r && (q.size() != 0);
      wa = w && ((q.size() < DEP) || ra);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      m_valid = ra;
      m_ovf   = w && !wa;
      m_unf   = r && !ra;
   endtask

   task automatic check_all(input string ctx);
      int sz;
      sz = q.size();
      chk({ctx, ":DATA_OUT"},     32'(bus.DATA_OUT),     32'(m_dout));
      chk({ctx, ":VALID_OUT"},    32'(bus.VALID_OUT),    32'(m_valid));
      chk({ctx, ":FULL"},         32'(bus.FULL),         32'(sz == DEP));
      chk({ctx, ":EMPTY"},        32'(bus.EMPTY),        32'(sz == 0));
      chk({ctx, ":almost_Full"},  32'(bus.almost_Full),  32'(sz >= AFT));
      chk({ctx, ":almost_Empty"}, 32'(bus.almost_Empty), 32'(sz <= AET));
      chk({ctx, ":FILL_LEVEL"},   32'(bus.FILL_LEVEL),   32'(sz));
      chk({ctx, ":OVERFLOW"},     32'(bus.OVERFLOW),     32'(m_ovf));
      chk({ctx, ":UNDERFLOW"},    32'(bus.UNDERFLOW),    32'(m_unf));
   endtask

   task automatic step(input string ctx, input logic w, input logic [DW-1:0] d, input logic r);
      bus.WRITE   = w;
      bus.DATA_IN = d;
      bus.READ    = r;
      @(posedge CLK);
      model_edge(w, d, r);
      #1;
      check_all(ctx);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.WRITE   = 1'b0;
      bus.DATA_IN = '0;
      bus.READ    = 1'b0;

      // Power-on reset, checked before any clock edge
      #1 RESET = 1'b0;
      #2;
      model_reset();
      check_all("rst");
      @(posedge CLK);
      #2 RESET = 1'b1;

      step("idle", 1'b0, 8'h00, 1'b0);
      chk("idle_fill_lit", 32'(bus.FILL_LEVEL), 32'd0);
      chk("idle_dout_lit", 32'(bus.DATA_OUT), 32'h00);

      // Fill with 0x11..0x88, then one overflow write
      for (int i = 1; i <= 8; i++) begin
         step("fill", 1'b1, 8'(i * 8'h11), 1'b0);
         if (i == 5) chk("af_before6_lit", 32'(bus.almost_Full), 32'd0);
         if (i == 6) chk("af_after6_lit", 32'(bus.almost_Full), 32'd1);
         if (i == 7) chk("full_before8_lit", 32'(bus.FULL), 32'd0);
      end
      chk("full_after8_lit", 32'(bus.FULL), 32'd1);
      step("ovf", 1'b1, 8'h99, 1'b0);
      chk("ovf_pulse_lit", 32'(bus.OVERFLOW), 32'd1);
      chk("ovf_fill_lit", 32'(bus.FILL_LEVEL), 32'd8);
      step("ovf_clear", 1'b0, 8'h00, 1'b0);

      // Drain in order, then one underflow read
      for (int i = 1; i <= 8; i++) begin
         step("drain", 1'b0, 8'h00, 1'b1);
         chk("drain_data_lit", 32'(bus.DATA_OUT), 32'(8'(i * 8'h11)));
      end
      chk("drain_empty_lit", 32'(bus.EMPTY), 32'd1);
      step("unf", 1'b0, 8'h00, 1'b1);
      chk("unf_pulse_lit", 32'(bus.UNDERFLOW), 32'd1);
      chk("unf_hold_lit", 32'(bus.DATA_OUT), 32'h88);
      step("unf_clear", 1'b0, 8'h00, 1'b0);

      // Pointer wrap: 5 in/out, then 6 in/out (0xA0..0xA5)
      for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 8'(8'hB0 + i), 1'b0);
      for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) step("wrap_w6", 1'b1, 8'(8'hA0 + i), 1'b0);
      for (int i = 0; i < 6; i++) begin
         step("wrap_r6", 1'b0, 8'h00, 1'b1);
         chk("wrap_data_lit", 32'(bus.DATA_OUT), 32'(8'hA0 + i));
      end
      chk("wrap_fill_lit", 32'(bus.FILL_LEVEL), 32'd0);

      // Simultaneous read+write at FULL
      for (int i = 0; i < 8; i++) step("sim_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
      step("sim_full_rw", 1'b1, 8'hEE, 1'b1);
      chk("sim_full_fill_lit", 32'(bus.FILL_LEVEL), 32'd8);
      chk("sim_full_ovf_lit", 32'(bus.OVERFLOW), 32'd0);
      for (int i = 0; i < 8; i++) step("sim_drain", 1'b0, 8'h00, 1'b1);
      chk("sim_ee_last_lit", 32'(bus.DATA_OUT), 32'hEE);

      // Simultaneous read+write at EMPTY: no bypass
      step("sim_empty_rw", 1'b1, 8'h5A, 1'b1);
      chk("sim_empty_fill_lit", 32'(bus.FILL_LEVEL), 32'd1);
      chk("sim_empty_unf_lit", 32'(bus.UNDERFLOW), 32'd1);
      step("sim_empty_rd", 1'b0, 8'h00, 1'b1);
      chk("sim_empty_data_lit", 32'(bus.DATA_OUT), 32'h5A);

      // Asynchronous reset mid-stream with 4 entries stored
      for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 8'(8'h30 + i), 1'b0);
      step("pre_rst_rd", 1'b0, 8'h00, 1'b1);
      step("pre_rst_w", 1'b1, 8'h34, 1'b0);
      bus.WRITE = 1'b0;
      bus.READ  = 1'b0;
      #2 RESET = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      chk("mid_rst_fill_lit", 32'(bus.FILL_LEVEL), 32'd0);
      #2 RESET = 1'b1;
      step("post_rst", 1'b0, 8'h00, 1'b0);
      step("post_rst_rd", 1'b0, 8'h00, 1'b1);
      chk("post_rst_unf_lit", 32'(bus.UNDERFLOW), 32'd1);

      // Random traffic with drifting write/read bias
      for (int i = 0; i < 400; i++) begin
         int wb;
         wb = ((i / 50) % 2 == 0) ? 70 : 30;
         step("rand",
              1'($urandom_range(0, 99) < wb),
              8'($urandom),
              1'($urandom_range(0, 99) < (100 - wb)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO: circular buffer with independent read and write pointers, registered output, and programmable almost-full/almost-empty flags. Successor to the fixed 8x8 byte buffer in the Buffer path. Adds explicit READ handshake, full/empty status, fill level, and over/underflow reporting. Sits between the byte-stream producer and the downstream consumer logic.

Parameters:
DATA_WIDTH, 8, bits per entry
DEPTH, 8, number of entries; power of 2, >= 4
AF_THRESH, DEPTH-2, almost_Full asserted when fill level >= AF_THRESH
AE_THRESH, 1, almost_Empty asserted when fill level <= AE_THRESH
AW, log2(DEPTH), pointer width (derived, not overridden)

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-low reset
WRITE  in  1  write request
DATA_IN  in  DATA_WIDTH  write data, sampled when write accepted
READ  in  1  read request
DATA_OUT  out  DATA_WIDTH  read data, registered
VALID_OUT  out  1  DATA_OUT updated this cycle (1-cycle pulse per accepted read)
FULL  out  1  fill level == DEPTH
EMPTY  out  1  fill level == 0
almost_Full  out  1  fill level >= AF_THRESH
almost_Empty  out  1  fill level <= AE_THRESH
FILL_LEVEL  out  AW+1  entries currently stored
OVERFLOW  out  1  1-cycle pulse: WRITE rejected
UNDERFLOW  out  1  1-cycle pulse: READ rejected

Behaviour:
- Reset (RESET=0, async, any time including mid-transfer): wr_ptr=rd_ptr=0, count=0, DATA_OUT=0, VALID_OUT=0, FULL=0, EMPTY=1, almost_Full=0, almost_Empty=1, FILL_LEVEL=0, OVERFLOW=0, UNDERFLOW=0. Storage array not cleared. Release takes effect at the next rising edge; no request accepted while RESET=0.
- Read accept: rd_acc = READ & ~EMPTY.
- Write accept: wr_acc = WRITE & (~FULL | rd_acc). Full with simultaneous read: both accepted, count unchanged.
- Empty with simultaneous READ and WRITE: write accepted; read rejected (no bypass); UNDERFLOW pulses.
- On wr_acc: mem[wr_ptr] <= DATA_IN; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
- On rd_acc: DATA_OUT <= mem[rd_ptr]; rd_ptr advances with the same wrap; VALID_OUT=1 the following cycle, else 0. DATA_OUT holds its last value when no read.
- Read latency: 1 cycle from the READ edge to DATA_OUT/VALID_OUT. Write-to-read latency: data written at edge N is readable by READ sampled at edge N+1.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Width AW+1; never exceeds DEPTH and never wraps below 0.
- FULL, EMPTY, almost_Full, almost_Empty, FILL_LEVEL are registered. They are computed from the next count, so they reflect the state after the edge, with no extra cycle of lag.
- OVERFLOW = registered (WRITE & ~wr_acc). UNDERFLOW = registered (READ & ~rd_acc). Each is a 1-cycle pulse per rejected request; rejected requests do not change pointers, count or storage.
- Thresholds: compared as unsigned against count. Out-of-range thresholds (AF_THRESH > DEPTH) leave the flag constant; no error.
- Controller state is fully described by {wr_ptr, rd_ptr, count}. There is no other FSM, and there are no illegal states.

Test Plan:
- Reset then idle -> EMPTY=1, almost_Empty=1, FILL_LEVEL=0, VALID_OUT=0, DATA_OUT=0x00.
- Defaults: write 0x11..0x88 on 8 consecutive cycles -> almost_Full=1 after the 6th write, FULL=1 after the 8th. A 9th write of 0x99 -> OVERFLOW pulse, FILL_LEVEL stays 8.
- From full, read 8 times -> DATA_OUT 0x11..0x88 in order, VALID_OUT high each following cycle, EMPTY=1 after the last read. A 9th READ -> UNDERFLOW pulse, DATA_OUT holds 0x88.
- Wrap: write 5, read 5, write 6, read 6 (0xA0..0xA5) -> data in order across the pointer wrap, FILL_LEVEL back to 0.
- Simultaneous ops: at FULL, READ+WRITE of 0xEE -> FILL_LEVEL stays 8, no OVERFLOW, and 0xEE is read out last. At EMPTY, READ+WRITE of 0x5A -> FILL_LEVEL=1, UNDERFLOW pulse, next READ returns 0x5A.
- Reset asserted mid-stream with 4 entries stored -> all outputs reach reset values immediately (without a clock edge); after release, FILL_LEVEL=0 and a READ gives UNDERFLOW.
